// File: rtl/multi_cycle_cla_adder_pkg.sv
// Shared types and helpers for the word-serial carry-lookahead adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package multi_cycle_cla_adder_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of chunk k in a word made of w-bit chunks, for use as [lsb +: w].
  function automatic int chunk_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/multi_cycle_cla_adder_cla.sv
// W-bit carry-lookahead stage: resolves generate/propagate bits into per-bit carries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it follows its inputs every cycle.
module carry_lookahead_unit #(
  parameter int W = 4
) (
  input  logic         cin,
  input  logic [W-1:0] g,
  input  logic [W-1:0] p,
  output logic [W-1:0] c
);

  logic term;

  // c[i] is the carry out of bit i, built as a flat sum of products with no ripple chain.
  always_comb begin
    c    = '0;
    term = 1'b0;
    for (int i = 0; i < W; i++) begin
      // Carry-in propagated through every bit up to i.
      term = cin;
      for (int j = 0; j <= i; j++) begin
        term = term & p[j];
      end
      c[i] = term;
      // Carry generated at bit j and propagated through bits j+1..i.
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
  end

endmodule

// File: rtl/multi_cycle_cla_adder.sv
// Word-serial adder: one W-bit lookahead chunk per cycle, LSB chunk first, carry chained via a register.
// Latency: accept edge plus N RUN cycles, so out_valid rises N+1 edges after acceptance.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
module multi_cycle_cla_adder
  import multi_cycle_cla_adder_pkg::*;
#(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] sum,
  output logic           cout,
  output logic           ovf
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [N*W-1:0] a_reg;
  logic [N*W-1:0] b_reg;
  logic [CW-1:0]  cnt;
  logic           carry;

  logic [W-1:0]   a_chunks [N];
  logic [W-1:0]   b_chunks [N];
  logic [W-1:0]   a_k;
  logic [W-1:0]   b_k;
  logic [W-1:0]   g;
  logic [W-1:0]   p;
  logic [W-1:0]   c;
  logic [W-1:0]   sum_chunk;

  // Split the latched operands into chunks so the counter can pick one with a plain mux.
  for (genvar i = 0; i < N; i++) begin : g_chunk
    assign a_chunks[i] = a_reg[chunk_lsb(i, W) +: W];
    assign b_chunks[i] = b_reg[chunk_lsb(i, W) +: W];
  end

  assign a_k = a_chunks[cnt];
  assign b_k = b_chunks[cnt];
  assign g   = a_k & b_k;
  assign p   = a_k ^ b_k;

  carry_lookahead_unit #(
    .W (W)
  ) u_cla (
    .cin (carry),
    .g   (g),
    .p   (p),
    .c   (c)
  );

  // Carry into each bit is the previous bit's carry out; bit 0 takes the chained carry.
  assign sum_chunk = p ^ {c[W-2:0], carry};
  assign in_ready  = (state == IDLE);

  // Controller: accept operands, sweep chunks, then hold the result until drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
              sum[chunk_lsb(i, W) +: W] <= sum_chunk;
            end
          end
          carry <= c[W-1];
          if (cnt == LAST) begin
            cout      <= c[W-1];
            ovf       <= c[W-1] ^ c[W-2];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_cla_adder.sv
// Self-checking bench for the word-serial lookahead adder (W=4, N=4, 16-bit operands).
// Expected results are queued when operands are offered and popped when out_valid is seen.
module tb_multi_cycle_cla_adder;

  localparam int W = 4;
  localparam int N = 4;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  multi_cycle_cla_adder #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: 17-bit add, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic ci);
    logic [16:0] full;
    exp_t e;
    full = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    e.s  = full[15:0];
    e.co = full[16];
    e.ov = (av[15] == bv[15]) && (full[15] != av[15]);
    return e;
  endfunction

  // Wait (bounded) for in_ready, offer one operand set, queue its expectation, return after the accept edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                      input exp_t e, output int ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    a        = av;
    b        = bv;
    cin      = ci;
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid shows (bounded).
  task automatic wait_out(output int cyc, output int ok);
    cyc = 0;
    ok  = 0;
    while (cyc < 50) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #2;
    total++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h1234};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h4321};
    logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_t        ve [4] = '{'{16'h0100, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0},
                            '{16'h8000, 1'b0, 1'b1}, '{16'h5556, 1'b0, 1'b0}};
    int ok, cyc;
    exp_t e;
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send(va[v], vb[v], vc[v], ve[v], ok);
      total++;
      if (!ok) $display("FAIL vec%0d_accept: in_ready never rose within 50 cycles, required high", v);
      else passed++;
      wait_out(cyc, ok);
      e = sb.pop_front();
      total++;
      // Accept edge plus N RUN edges: out_valid visible N edges after the edge send() returned on.
      if (!ok || cyc != N) $display("FAIL vec%0d_latency: out_valid after %0d edges (seen=%0d), required %0d", v, cyc + 1, ok, N + 1);
      else passed++;
      total++;
      if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
        $display("FAIL vec%0d_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 v, sum, cout, ovf, e.s, e.co, e.ov);
      end else passed++;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL vec%0d_drain: out_valid=%b in_ready=%b, required 0 1", v, out_valid, in_ready);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    int ok, cyc, bad;
    exp_t e;
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b0, '{16'h1010, 1'b0, 1'b0}, ok);
    wait_out(cyc, ok);
    e = sb.pop_front();
    total++;
    if (!ok || {sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
      $display("FAIL bp_first: seen=%0d sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               ok, sum, cout, ovf, e.s, e.co, e.ov);
    end else passed++;
    // New operands offered while the result is stalled.
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    sb.push_back(model(16'h1111, 16'h2222, 1'b0));
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== {e.s, e.co, e.ov}) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold: %0d of 6 stalled cycles unstable or accepting, required 0", bad);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) $display("FAIL bp_accept_next: in_ready=%b after IDLE edge, required 0", in_ready);
    else passed++;
    wait_out(cyc, ok);
    e = sb.pop_front();
    total++;
    if (!ok || cyc != N || {sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
      $display("FAIL bp_second: seen=%0d edges=%0d sum=%h cout=%b ovf=%b, required edges=%0d sum=%h cout=%b ovf=%b",
               ok, cyc + 1, sum, cout, ovf, N + 1, e.s, e.co, e.ov);
    end else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int ok, cyc, seen;
    exp_t e;
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, model(16'hFFFF, 16'h0001, 1'b0), ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL rst_busy: in_ready=%b during RUN, required 0", in_ready);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      $display("FAIL rst_mid_run: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end else passed++;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL rst_no_pulse: out_valid high %0d cycles after reset, required 0", seen);
    else passed++;
    send(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0}, ok);
    wait_out(cyc, ok);
    e = sb.pop_front();
    total++;
    if (!ok || {sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
      $display("FAIL rst_after: seen=%0d sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               ok, sum, cout, ovf, e.s, e.co, e.ov);
    end else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   cyc, sent, got, last, bad_gap;
    logic pend;
    exp_t e;
    cyc      = 0;
    sent     = 0;
    got      = 0;
    last     = -1;
    bad_gap  = 0;
    out_ready = 1'b1;
    a        = 16'($urandom());
    b        = 16'($urandom());
    cin      = 1'($urandom());
    in_valid = 1'b1;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL b2b_unexpected: result sum=%h with empty scoreboard, required none", sum);
        end else begin
          e = sb.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     got, sum, cout, ovf, e.s, e.co, e.ov);
          end else passed++;
        end
        if (last >= 0 && cyc - last != N + 2) bad_gap++;
        last = cyc;
        got++;
      end
      pend = in_ready && (sent < 10);
      if (pend) sb.push_back(model(a, b, cin));
      @(posedge clk); #1;
      if (pend) begin
        sent++;
        if (sent < 10) begin
          a   = 16'($urandom());
          b   = 16'($urandom());
          cin = 1'($urandom());
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (got != 10) $display("FAIL b2b_count: %0d results within budget, required 10", got);
    else passed++;
    total++;
    if (bad_gap != 0) $display("FAIL b2b_rate: %0d result gaps differ from %0d cycles, required 0", bad_gap, N + 2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
